config_cmd_tx: RTL
==================

# config_cmd_tx

Command transmitter that turns high-level configuration requests into the 4-bit instruction stream consumed by the FIR configuration decoder. Sits on the write side of the command FIFO: the host side presents one request at a time over a valid/ready handshake. The block serialises each request into one or two nibbles, pushes them into the FIFO under `full` back-pressure, and keeps shadow copies of the coefficients and FIR on/off state the decoder will hold.

## Interface
- `AUTO_REBOOT`, default 0: when 1, a write request whose capture found the FIR on (`fir_on_shadow`=1) appends a boot nibble after the data nibble.
- `CNT_W`, default 16: width of the issued-nibble counter.

- `clk` in 1: single clock, all state on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_op` in 2: 00 null, 01 write coefficient, 10 boot FIR, 11 shutdown FIR.
- `req_sel` in 1: coefficient target for write, 0 = w0, 1 = w1.
- `req_data` in 4: coefficient value for write.
- `full` in 1: command FIFO full.
- `wr_en` out 1: FIFO push strobe.
- `dout` out 4: nibble pushed when `wr_en`=1.
- `busy` out 1: request in progress, i.e. state != IDLE.
- `fir_on_shadow` out 1: FIR state implied by nibbles already pushed.
- `shadow_w0`, `shadow_w1` out 4 each: coefficients implied by nibbles already pushed.
- `tx_count` out CNT_W: total nibbles pushed, wraps modulo 2^CNT_W.

## Operation
- Instruction nibble format: `dout[3:2]` = opcode, `dout[1:0]` = select.
  - Bit 1 of select chooses the coefficient: 0 = w0, 1 = w1. Bit 0 is always 0.
  - Write header: {01, sel, 0}. Data nibble: raw `req_data`.
  - Boot: 4'b1000. Shutdown: 4'b1100.
  - No 00 nibble is ever pushed.
- FSM states: IDLE, HDR, DATA, BOOT, SHUT.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, capture `req_op`, `req_sel`, `req_data`.
  - Also capture the reboot flag = `AUTO_REBOOT` && `fir_on_shadow`.
  - Next state by op: write → HDR, boot → BOOT, shutdown → SHUT, null → IDLE. A null request is consumed with no push.
- HDR, DATA, BOOT, SHUT: `req_ready`=0.
  - `wr_en` = !`full`; `dout` = the nibble for the current state.
  - The state advances only on a cycle with `wr_en`=1; otherwise it holds and `dout` stays stable.
- Transitions on push:
  - HDR → DATA.
  - DATA → BOOT if the reboot flag is set, else → IDLE.
  - BOOT → IDLE.
  - SHUT → IDLE.
- `wr_en`, `dout`, and `req_ready` are combinational from state, captured registers, and `full`. `dout` = 0 in IDLE.
- Shadow updates, registered, on the push cycle:
  - Header push clears `fir_on_shadow`, matching the decoder closing the FIR on a write.
  - Data push loads `shadow_w0` or `shadow_w1` per the captured sel.
  - Boot push sets `fir_on_shadow`.
  - Shutdown push clears `fir_on_shadow`.
- `tx_count` increments by 1 on every push and wraps from all-ones to 0.
- Reset (any time, including mid-sequence) values:
  - State IDLE.
  - `wr_en`=0, `dout`=0, `busy`=0, `req_ready`=1.
  - Shadows 0, `tx_count` 0.
  - A header already pushed without its data nibble is abandoned; recovery is a system-level decoder/FIFO reset.

## Timing
- Request accepted in cycle N (`req_valid` & `req_ready`). First push possible in cycle N+1.
- Latency with `full`=0:
  - Write: pushes in N+1 (header) and N+2 (data). `req_ready` returns in N+3.
  - Write with reboot flag: adds a boot push in N+3; `req_ready` returns in N+4.
  - Boot or shutdown: push in N+1; `req_ready` returns in N+2.
- Null: `req_ready` stays 1 in N+1 and no push occurs.
- Each cycle of `full`=1 in a non-IDLE state adds exactly one cycle of delay. No nibble is dropped or duplicated.
- Shadow and count registers reflect a push from the cycle after `wr_en`=1.
- A `full` change while in IDLE has no effect.

## Test plan
- Reset, then write w1 = 4'hA with `full`=0: `dout` 4'b0110 then 4'hA on consecutive cycles; `shadow_w1`=A, `tx_count`=2, `req_ready` back 3 cycles after accept.
- Boot, then write w0 = 4'h5 with `AUTO_REBOOT`=1: pushes 1000, 0100, 0101, 1000; `fir_on_shadow` ends at 1, `tx_count`=4.
- Write w0 = 4'h3 with `full` held high for 3 cycles starting at the header: header held for 3 cycles, `wr_en`=0 throughout; pushes then resume; exactly 2 pushes total.
- Null request followed immediately by shutdown: no push for null; single push 1100 for shutdown; `fir_on_shadow`=0.
- Assert `rstn` low in DATA after the header push: all outputs at reset values at once, asynchronously; next request starts cleanly from IDLE.
- `CNT_W`=2, five boot requests: `tx_count` sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/config_cmd_tx.sv
// -----------------------------------------------------------------------------
// config_cmd_tx
//
// Command transmitter for the FIR configuration decoder. Accepts one
// high-level request at a time and serialises it into 4-bit instruction
// nibbles pushed into the command FIFO. It also tracks the decoder state that
// the pushed nibbles imply (FIR on/off and both coefficients).
//
// Nibble format: [3:2] opcode, [1:0] select ([1] = coefficient, [0] = 0).
//   write header : {2'b01, sel, 1'b0}  followed by the raw data nibble
//   boot         : 4'b1000
//   shutdown     : 4'b1100
//
// Parameters
//   AUTO_REBOOT : a write accepted while the FIR is on appends a boot nibble
//   CNT_W       : width of the pushed-nibble counter (wraps)
//
// Ports
//   clk, rstn          : clock, asynchronous active-low reset
//   req_valid/ready    : request handshake
//   req_op             : 00 null, 01 write, 10 boot, 11 shutdown
//   req_sel, req_data  : coefficient target and value for a write
//   full               : FIFO back-pressure
//   wr_en, dout        : FIFO push strobe and nibble
//   busy               : a request is being serialised
//   fir_on_shadow      : FIR state implied by pushed nibbles
//   shadow_w0/w1       : coefficients implied by pushed nibbles
//   tx_count           : number of nibbles pushed, modulo 2^CNT_W
//   dbg_state          : current FSM state for observation
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready depends only on state, so it never waits on
// req_valid. A FIFO push happens on a rising edge where wr_en is 1; wr_en is
// only raised when full is 0, and dout holds its value until that push.
// -----------------------------------------------------------------------------
module config_cmd_tx #(
    parameter bit          AUTO_REBOOT = 1'b0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic             req_sel,
    input  logic [3:0]       req_data,
    input  logic             full,
    output logic             wr_en,
    output logic [3:0]       dout,
    output logic             busy,
    output logic             fir_on_shadow,
    output logic [3:0]       shadow_w0,
    output logic [3:0]       shadow_w1,
    output logic [CNT_W-1:0] tx_count,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_BOOT = 3'd3,
        S_SHUT = 3'd4
    } state_e;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_BOOT  = 2'b10;
    localparam logic [1:0] OP_SHUT  = 2'b11;

    localparam logic [3:0] NIB_BOOT = 4'b1000;
    localparam logic [3:0] NIB_SHUT = 4'b1100;

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic [3:0]       data_q, data_d;
    logic             reboot_q, reboot_d;
    logic             fir_on_q, fir_on_d;
    logic [3:0]       w0_q, w0_d;
    logic [3:0]       w1_q, w1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            sel_q    <= 1'b0;
            data_q   <= 4'h0;
            reboot_q <= 1'b0;
            fir_on_q <= 1'b0;
            w0_q     <= 4'h0;
            w1_q     <= 4'h0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            reboot_q <= reboot_d;
            fir_on_q <= fir_on_d;
            w0_q     <= w0_d;
            w1_q     <= w1_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        data_d    = data_q;
        reboot_d  = reboot_q;
        fir_on_d  = fir_on_q;
        w0_d      = w0_q;
        w1_d      = w1_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        wr_en     = 1'b0;
        dout      = 4'h0;

        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    sel_d    = req_sel;
                    data_d   = req_data;
                    // Reboot decision is frozen at accept time; the header push
                    // clears the shadow before the data nibble goes out.
                    reboot_d = AUTO_REBOOT & fir_on_q;
                    case (req_op)
                        OP_WRITE: state_d = S_HDR;
                        OP_BOOT:  state_d = S_BOOT;
                        OP_SHUT:  state_d = S_SHUT;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_HDR: begin
                wr_en = !full;
                dout  = {2'b01, sel_q, 1'b0};
                if (wr_en) begin
                    state_d  = S_DATA;
                    // The decoder closes the FIR when it sees a write header.
                    fir_on_d = 1'b0;
                end
            end
            S_DATA: begin
                wr_en = !full;
                dout  = data_q;
                if (wr_en) begin
                    state_d = reboot_q ? S_BOOT : S_IDLE;
                    if (sel_q) w1_d = data_q;
                    else       w0_d = data_q;
                end
            end
            S_BOOT: begin
                wr_en = !full;
                dout  = NIB_BOOT;
                if (wr_en) begin
                    state_d  = S_IDLE;
                    fir_on_d = 1'b1;
                end
            end
            S_SHUT: begin
                wr_en = !full;
                dout  = NIB_SHUT;
                if (wr_en) begin
                    state_d  = S_IDLE;
                    fir_on_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wr_en) cnt_d = cnt_q + CNT_W'(1);
    end

    assign busy          = (state_q != S_IDLE);
    assign fir_on_shadow = fir_on_q;
    assign shadow_w0     = w0_q;
    assign shadow_w1     = w1_q;
    assign tx_count      = cnt_q;
    assign dbg_state     = state_q;

endmodule
